// File: rtl/parity_frame_ctrl_if.sv
// Frame-level handshake between the serial line front-end and the parity frame controller.
// The master drives the serial bit stream and frame control; the slave reports results.
interface parity_frame_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 6
);
  logic              start;
  logic              data;
  logic              bit_valid;
  logic              abort;
  logic              busy;
  logic              done;
  logic              par_err;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output start, data, bit_valid, abort,
    input  busy, done, par_err, data_out, frame_cnt, err_cnt
  );

  modport slave (
    input  start, data, bit_valid, abort,
    output busy, done, par_err, data_out, frame_cnt, err_cnt
  );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Frame sequencer for the serial parity datapath: captures DATA_W bits plus a parity bit,
// checks parity and keeps frame / error counters for status readout.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_DATA   | accepting data bits on bit_valid
// S_PAR    | waiting for the parity bit
// S_REPORT | one-cycle done pulse with the frame result
module parity_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_frame_ctrl_if.slave bus
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic ODD_B = 1'(ODD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PAR    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               acc;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  data_out_q;
  logic               par_err_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic               bit_take;
  logic               par_take;
  logic               frame_err;

  // abort outranks bit_valid, so a bit arriving with abort is never consumed
  assign bit_take  = (state == S_DATA) && bus.bit_valid && !bus.abort;
  assign par_take  = (state == S_PAR)  && bus.bit_valid && !bus.abort;
  assign frame_err = acc ^ bus.data ^ ODD_B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bus.abort)                       state_nxt = S_IDLE;
        else if (bit_take && idx == LAST_IDX) state_nxt = S_PAR;
      end
      S_PAR: begin
        if (bus.abort)     state_nxt = S_IDLE;
        else if (par_take) state_nxt = S_REPORT;
      end
      S_REPORT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      S_DATA:   bus.busy = 1'b1;
      S_PAR:    bus.busy = 1'b1;
      S_REPORT: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      acc         <= 1'b0;
      shreg       <= '0;
      data_out_q  <= '0;
      par_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        idx <= '0;
        acc <= 1'b0;
      end
      if (bit_take) begin
        shreg[idx] <= bus.data;
        acc        <= acc ^ bus.data;
        idx        <= idx + IDX_W'(1);
      end
      if (par_take) begin
        data_out_q  <= shreg;
        par_err_q   <= frame_err;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        if (frame_err && err_cnt_q != {CNT_W{1'b1}}) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.par_err   = par_err_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: an even-parity and an odd-parity instance share one stimulus
// stream and are compared every cycle against a frame-level reference model.
module tb_parity_frame_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 6;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  parity_frame_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_e ();
  parity_frame_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_o ();

  parity_frame_ctrl #(.DATA_W(DATA_W), .ODD(0), .CNT_W(CNT_W)) u_even (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e.slave)
  );

  parity_frame_ctrl #(.DATA_W(DATA_W), .ODD(1), .CNT_W(CNT_W)) u_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_o.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: frame-level view, not a state machine copy
  bit          m_in;
  bit          m_rep;
  int          m_n;
  logic [31:0] m_word;
  logic [31:0] m_dout;
  int          m_fcnt;
  bit          m_perr [2];
  int          m_ecnt [2];

  typedef struct {
    bit          st, d, bv, ab;
    bit          busy, done, perr_e, perr_o;
    logic [7:0]  dout;
    int          fcnt, ecnt_e, ecnt_o;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_rep = 0; m_n = 0; m_word = '0; m_dout = '0; m_fcnt = 0;
    m_perr[0] = 0; m_perr[1] = 0; m_ecnt[0] = 0; m_ecnt[1] = 0;
  endtask

  task automatic model_edge(input bit st, input bit d, input bit bv, input bit ab);
    int ones;
    if (m_rep) begin
      m_rep = 0;
    end else if (!m_in) begin
      if (st) begin
        m_in = 1; m_n = 0; m_word = '0;
      end
    end else if (ab) begin
      m_in = 0;
    end else if (bv) begin
      if (m_n < DATA_W) begin
        m_word[m_n] = d;
        m_n++;
      end else begin
        ones = $countones(m_word) + int'(d);
        for (int k = 0; k < 2; k++) begin
          m_perr[k] = ((ones % 2) != k);
          if (m_perr[k] && m_ecnt[k] < CMAX) m_ecnt[k]++;
        end
        m_dout = m_word;
        m_fcnt = (m_fcnt + 1) % (CMAX + 1);
        m_in   = 0;
        m_rep  = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("busy_e",  32'(bus_e.busy),      32'(m_in));
    chk("busy_o",  32'(bus_o.busy),      32'(m_in));
    chk("done_e",  32'(bus_e.done),      32'(m_rep));
    chk("done_o",  32'(bus_o.done),      32'(m_rep));
    chk("perr_e",  32'(bus_e.par_err),   32'(m_perr[0]));
    chk("perr_o",  32'(bus_o.par_err),   32'(m_perr[1]));
    chk("dout_e",  32'(bus_e.data_out),  m_dout & 32'hFF);
    chk("dout_o",  32'(bus_o.data_out),  m_dout & 32'hFF);
    chk("fcnt_e",  32'(bus_e.frame_cnt), 32'(m_fcnt));
    chk("fcnt_o",  32'(bus_o.frame_cnt), 32'(m_fcnt));
    chk("ecnt_e",  32'(bus_e.err_cnt),   32'(m_ecnt[0]));
    chk("ecnt_o",  32'(bus_o.err_cnt),   32'(m_ecnt[1]));
  endtask

  task automatic drive(input bit st, input bit d, input bit bv, input bit ab);
    bus_e.start = st; bus_e.data = d; bus_e.bit_valid = bv; bus_e.abort = ab;
    bus_o.start = st; bus_o.data = d; bus_o.bit_valid = bv; bus_o.abort = ab;
  endtask

  task automatic step(input bit st, input bit d, input bit bv, input bit ab);
    drive(st, d, bv, ab);
    @(posedge clk);
    model_edge(st, d, bv, ab);
    #1;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'({bus_e.busy, bus_o.busy}), 32'd0);
    chk({tag, "_done"}, 32'({bus_e.done, bus_o.done}), 32'd0);
    chk({tag, "_perr"}, 32'({bus_e.par_err, bus_o.par_err}), 32'd0);
    chk({tag, "_dout"}, 32'({bus_e.data_out, bus_o.data_out}), 32'd0);
    chk({tag, "_fcnt"}, 32'({bus_e.frame_cnt, bus_o.frame_cnt}), 32'd0);
    chk({tag, "_ecnt"}, 32'({bus_e.err_cnt, bus_o.err_cnt}), 32'd0);
  endtask

  function automatic vec_t mk(input bit st, d, bv, ab, busy, done, pe, po,
                              input logic [7:0] dout, input int f, ee, eo);
    vec_t v;
    v.st = st; v.d = d; v.bv = bv; v.ab = ab;
    v.busy = busy; v.done = done; v.perr_e = pe; v.perr_o = po;
    v.dout = dout; v.fcnt = f; v.ecnt_e = ee; v.ecnt_o = eo;
    return v;
  endfunction

  initial begin
    logic [7:0] w;
    logic [7:0] pat;
    int         done_seen;
    int         busy_gaps;
    int         f_before;
    bit         par;

    pat = 8'h0D;

    // frame 1: 0x0D with parity 1 (good even, bad odd); frame 2: parity 0 (bad even, good odd)
    tbl.push_back(mk(1,0,0,0, 1,0,0,0, 8'h00,0,0,0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0,pat[i],1,0, 1,0,0,0, 8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,0, 0,1,0,1, 8'h0D,1,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1, 8'h0D,1,0,1));
    tbl.push_back(mk(1,0,0,0, 1,0,0,1, 8'h0D,1,0,1));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0,pat[i],1,0, 1,0,0,1, 8'h0D,1,0,1));
    tbl.push_back(mk(0,0,1,0, 0,1,1,0, 8'h0D,2,1,1));
    tbl.push_back(mk(0,0,0,0, 0,0,1,0, 8'h0D,2,1,1));

    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].d, tbl[i].bv, tbl[i].ab);
      chk($sformatf("tbl%0d_busy", i), 32'(bus_e.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(bus_e.done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_perr_e", i), 32'(bus_e.par_err), 32'(tbl[i].perr_e));
      chk($sformatf("tbl%0d_perr_o", i), 32'(bus_o.par_err), 32'(tbl[i].perr_o));
      chk($sformatf("tbl%0d_dout", i), 32'(bus_e.data_out), 32'(tbl[i].dout));
      chk($sformatf("tbl%0d_fcnt", i), 32'(bus_e.frame_cnt), 32'(tbl[i].fcnt));
      chk($sformatf("tbl%0d_ecnt_e", i), 32'(bus_e.err_cnt), 32'(tbl[i].ecnt_e));
      chk($sformatf("tbl%0d_ecnt_o", i), 32'(bus_o.err_cnt), 32'(tbl[i].ecnt_o));
    end

    // stalled frame with a stray start in the middle
    done_seen = 0;
    busy_gaps = 0;
    f_before  = m_fcnt;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, pat[i], 1, 0);
      for (int s = 0; s < 3; s++) begin
        step((i == 3 && s == 1), 0, 0, 0);
        if (!bus_e.busy) busy_gaps++;
        if (bus_e.done) done_seen++;
      end
    end
    step(0, 1, 1, 0);
    if (bus_e.done) done_seen++;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      if (bus_e.done) done_seen++;
    end
    chk("stall_busy_gaps", 32'(busy_gaps), 32'd0);
    chk("stall_done_cnt", 32'(done_seen), 32'd1);
    chk("stall_dout", 32'(bus_e.data_out), 32'h0D);
    chk("stall_perr", 32'(bus_e.par_err), 32'd0);
    chk("stall_fcnt", 32'(bus_e.frame_cnt), 32'((f_before + 1) % (CMAX + 1)));

    // abort after 4 bits, then a full good frame
    f_before  = m_fcnt;
    done_seen = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, pat[i], 1, 0);
    step(0, 1, 1, 1);
    if (bus_e.done) done_seen++;
    chk("abort_busy", 32'(bus_e.busy), 32'd0);
    step(0, 0, 0, 0);
    if (bus_e.done) done_seen++;
    chk("abort_no_done", 32'(done_seen), 32'd0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, pat[i], 1, 0);
    step(0, 1, 1, 0);
    chk("abort_next_done", 32'(bus_e.done), 32'd1);
    chk("abort_fcnt", 32'(bus_e.frame_cnt), 32'((f_before + 1) % (CMAX + 1)));
    step(0, 0, 0, 0);

    // abort coincident with the parity bit
    f_before = m_fcnt;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, pat[i], 1, 0);
    step(0, 0, 1, 1);
    chk("abort_par_done", 32'(bus_e.done), 32'd0);
    step(0, 0, 0, 0);
    chk("abort_par_done2", 32'(bus_e.done), 32'd0);
    chk("abort_par_fcnt", 32'(bus_e.frame_cnt), 32'(f_before));

    // start together with abort in idle still opens a frame
    step(1, 0, 0, 1);
    chk("start_abort_idle", 32'(bus_e.busy), 32'd1);
    step(0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < 30; i++) step(0, 0, 1, 1);

    // counter limits from a clean reset
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst2");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int f = 0; f < 64; f++) begin
      w = 8'($urandom);
      par = ~(^w);
      par = ~par;
      par = (^w) ^ 1'b1;
      step(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, w[i], 1, 0);
      step(0, par, 1, 0);
      step(0, 0, 0, 0);
    end
    chk("sat_ecnt", 32'(bus_e.err_cnt), 32'(CMAX));
    chk("wrap_fcnt", 32'(bus_e.frame_cnt), 32'd0);
    chk("sat_ecnt_odd", 32'(bus_o.err_cnt), 32'd0);

    // async reset in the middle of a frame
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, pat[i], 1, 0);
    step(0, 1, 1, 0);
    chk("post_rst_fcnt", 32'(bus_e.frame_cnt), 32'd1);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_frame_ctrl.md
Name: parity_frame_ctrl

Overview:
Sequences the serial parity datapath on a frame basis. Accepts a start pulse, then DATA_W serial data bits and one parity bit on a bit-valid strobe. It accumulates running parity, checks the received parity bit and reports the captured word with a pass/fail flag. Keeps frame and error counters for status readout. Sits between the serial line front-end and the status/register block.

Parameters:
DATA_W, 8, number of data bits per frame (2..32)
ODD, 0, 0 = even parity (data + parity bit has even ones count), 1 = odd parity
CNT_W, 6, width of frame and error counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  frame start pulse; honoured only in IDLE
data  in  1  serial bit; sampled when bit_valid=1
bit_valid  in  1  qualifies data for one cycle
abort  in  1  drop current frame, return to IDLE
busy  out  1  high in DATA and PAR states
done  out  1  one-cycle pulse in REPORT
par_err  out  1  parity result, valid while done=1, held until next done
data_out  out  DATA_W  captured word, LSB = first bit received, held until next done
frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W
err_cnt  out  CNT_W  frames with parity error, saturates at 2^CNT_W-1

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, par_err=0, data_out=0, frame_cnt=0, err_cnt=0; internal acc=0, bit index=0.
- FSM states: IDLE, DATA, PAR, REPORT. All outputs are registered.
- IDLE: start=1 -> DATA. On entry to DATA, clear acc and the bit index. bit_valid in IDLE is ignored.
- DATA: on each bit_valid=1:
  - shreg[idx] <= data
  - acc <= acc ^ data
  - idx <= idx+1
  - On the DATA_W-th accepted bit -> PAR.
  - Cycles with bit_valid=0 stall without limit; no timeout.
- PAR: on bit_valid=1:
  - err = acc ^ data ^ ODD
  - data_out <= shreg
  - par_err <= err
  - frame_cnt += 1 (wraps)
  - if err, err_cnt += 1, saturating
  - -> REPORT
- REPORT: done=1 for exactly one cycle, then -> IDLE unconditionally. start or bit_valid in REPORT is ignored, so the minimum frame spacing is 1 idle cycle.
- Latency: done is asserted the cycle after the parity bit is accepted.
- abort=1 in DATA or PAR: -> IDLE next cycle. No done pulse, counters and data_out unchanged. abort has priority over bit_valid in the same cycle. abort in IDLE/REPORT has no effect (REPORT still completes).
- start while busy is ignored and does not restart the frame.
- Simultaneous start and abort in IDLE: start wins (abort has no effect in IDLE).
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.
- busy = (state==DATA)||(state==PAR); the combinational decode of the state register is acceptable.

Test Plan:
- Reset/idle: hold rst_n=0, then release with no stimulus -> all outputs 0 and busy=0 for 20 cycles.
- Good frame, even parity: start, bits 1,0,1,1,0,0,0,0 (data_out=8'h0D), parity bit 1 -> done 1 cycle after parity bit, par_err=0, data_out=8'h0D, frame_cnt=1, err_cnt=0.
- Bad frame: same data with parity bit 0 -> par_err=1, frame_cnt=2, err_cnt=1. With ODD=1, parity bit 0 -> par_err=0.
- Stalls and ignored start: insert 3 bit_valid=0 cycles between each bit and pulse start mid-frame -> same result as the unstalled frame, busy continuous, one done only.
- Abort: abort after 4 bits, then a full good frame -> no done for the aborted frame, frame_cnt increments by exactly 1; abort in the same cycle as the parity bit -> no done, counters unchanged.
- Counter limits (CNT_W=6): 64 bad frames -> err_cnt=63 saturated, frame_cnt=0 wrapped; then async reset mid-frame -> all outputs 0 immediately.
